// File: rtl/egg_timer_pkg.sv
// Shared egg-timer definitions: alarm sequencer state encoding and tone-index limits
// (the tone generator decodes tone_sel against the same NUM_TONES/MAX_TONE).
package egg_timer_pkg;

  localparam int unsigned NUM_TONES = 5;
  localparam int unsigned MAX_TONE  = NUM_TONES - 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BEEP_ON  = 3'd1,
    BEEP_OFF = 3'd2,
    PAUSE    = 3'd3,
    HOLD     = 3'd4
  } alarm_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [2:0] clamp_tone(input logic [2:0] sel);
    return (sel > 3'(MAX_TONE)) ? 3'(MAX_TONE) : sel;
  endfunction

  function automatic logic [2:0] next_tone(input logic [2:0] sel);
    return (sel >= 3'(NUM_TONES - 1)) ? 3'd0 : sel + 3'd1;
  endfunction

endpackage

// File: rtl/alarm_sequencer_rise_detect.sv
// Registered 0->1 edge detector; a level already high when reset releases is not an edge.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic hist_q;
  logic primed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= level_i;
      primed_q <= 1'b1;
    end
  end

  // The first sample after reset only seeds the history.
  assign rise_o = level_i & ~hist_q & primed_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Egg-timer alarm cadence controller: beep/pause bursts on the rising edge of 00:00.
// Define ALARM_TONE_ROTATE_EN to step tone_sel by one (mod NUM_TONES) at each new burst.
module alarm_sequencer
  import egg_timer_pkg::*;
#(
  parameter int unsigned ON_TICKS        = 20,
  parameter int unsigned OFF_TICKS       = 10,
  parameter int unsigned BEEPS_PER_BURST = 3,
  parameter int unsigned PAUSE_TICKS     = 100,
  parameter int unsigned MAX_BURSTS      = 30
) (
  input  logic       CLK100MHZ,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       endtime,
  input  logic       ack,
  input  logic [2:0] audioselection,
  output logic       tone_en,
  output logic [2:0] tone_sel,
  output logic       alarm_active,
  output logic       alarm_timeout
);

  localparam int unsigned PH_MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned PH_MAX   = (PH_MAX_A > PAUSE_TICKS) ? PH_MAX_A : PAUSE_TICKS;
  localparam int unsigned PH_W     = cnt_width(PH_MAX);
  localparam int unsigned BEEP_W   = cnt_width(BEEPS_PER_BURST);
  localparam int unsigned BURST_W  = cnt_width(MAX_BURSTS);

  localparam logic [PH_W-1:0]    ON_LAST    = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]    OFF_LAST   = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0]    PAUSE_LAST = PH_W'(PAUSE_TICKS - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LAST  = BEEP_W'(BEEPS_PER_BURST - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURSTS - 1);

  alarm_state_e       state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BEEP_W-1:0]  beep_q, beep_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [2:0]         tone_q, tone_d;
  logic               tone_en_q, tone_en_d;
  logic               active_q, active_d;
  logic               timeout_q, timeout_d;
  logic               timeout_evt;
  logic               rise;
  logic               in_phase;
  logic               phase_end;
  logic [PH_W-1:0]    phase_last;

  rise_detect u_rise (
    .clk_i   (CLK100MHZ),
    .rst_ni  (reset_n),
    .level_i (endtime),
    .rise_o  (rise)
  );

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      beep_q    <= '0;
      burst_q   <= '0;
      tone_q    <= '0;
      tone_en_q <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      beep_q    <= beep_d;
      burst_q   <= burst_d;
      tone_q    <= tone_d;
      tone_en_q <= tone_en_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    in_phase   = (state_q == BEEP_ON) || (state_q == BEEP_OFF) || (state_q == PAUSE);
    phase_last = PAUSE_LAST;
    if (state_q == BEEP_ON) begin
      phase_last = ON_LAST;
    end else if (state_q == BEEP_OFF) begin
      phase_last = OFF_LAST;
    end
    phase_end = tick && (phase_q == phase_last);
  end

  always_comb begin
    state_d     = state_q;
    beep_d      = beep_q;
    burst_d     = burst_q;
    tone_d      = tone_q;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = BEEP_ON;
          tone_d  = clamp_tone(audioselection);
          beep_d  = '0;
          burst_d = '0;
        end
      end
      BEEP_ON, BEEP_OFF, PAUSE: begin
        // Timer leaving 00:00 outranks ack, which outranks the cadence.
        if (!endtime) begin
          state_d = IDLE;
        end else if (ack) begin
          state_d = HOLD;
        end else if (phase_end) begin
          if (state_q == BEEP_ON) begin
            state_d = (beep_q < BEEP_LAST) ? BEEP_OFF : PAUSE;
          end else if (state_q == BEEP_OFF) begin
            state_d = BEEP_ON;
            beep_d  = beep_q + BEEP_W'(1);
          end else if (burst_q == BURST_LAST) begin
            state_d     = HOLD;
            timeout_evt = 1'b1;
          end else begin
            state_d = BEEP_ON;
            burst_d = burst_q + BURST_W'(1);
            beep_d  = '0;
`ifdef ALARM_TONE_ROTATE_EN
            tone_d  = next_tone(tone_q);
`else
            tone_d  = tone_q;
`endif
          end
        end
      end
      HOLD: begin
        if (!endtime) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase counter restarts on every state entry and only runs inside cadence states.
  always_comb begin
    phase_d = phase_q;
    if (state_d != state_q) begin
      phase_d = '0;
    end else if (in_phase && tick) begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  always_comb begin
    tone_en_d = (state_q == BEEP_ON);
    active_d  = in_phase;
    timeout_d = timeout_evt;
  end

  assign tone_en       = tone_en_q;
  assign tone_sel      = tone_q;
  assign alarm_active  = active_q;
  assign alarm_timeout = timeout_q;

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Controller that sequences the alarm tone generator when the egg timer countdown expires. It detects the rising edge of the timer's 00:00 condition and drives the tone generator's enable and tone select in a beep/pause cadence. It stops on user acknowledge, on timeout, or when the timer leaves 00:00. It sits between the countdown timer and the audio tone generator, in place of the direct 00:00 → audio connection.

## Interface
Parameters:
- ON_TICKS, 20: tick strobes per beep (tone on)
- OFF_TICKS, 10: tick strobes of silence between beeps within a burst
- BEEPS_PER_BURST, 3: beeps per burst
- PAUSE_TICKS, 100: tick strobes of silence between bursts
- MAX_BURSTS, 30: bursts before automatic timeout

Ports:
- CLK100MHZ  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle cadence strobe (nominally every 10 ms), synchronous to CLK100MHZ
- endtime  in  1  level; high while the timer reads 00:00
- ack  in  1  level; debounced user "end sound" input
- audioselection  in  3  requested tone index
- tone_en  out  1  enable to the tone generator
- tone_sel  out  3  tone index to the tone generator, range 0..4
- alarm_active  out  1  high in BEEP_ON, BEEP_OFF and PAUSE
- alarm_timeout  out  1  one-cycle pulse when MAX_BURSTS completes without ack

## Operation
- States: IDLE, BEEP_ON, BEEP_OFF, PAUSE, HOLD.
- IDLE: endtime sampled high with the previous sample low → BEEP_ON. On the same edge:
  - latch tone_sel = min(audioselection, 4);
  - clear the beep and burst counters.
- BEEP_ON: tone_en = 1. After ON_TICKS strobes:
  - beep count < BEEPS_PER_BURST-1 → BEEP_OFF;
  - otherwise → PAUSE.
- BEEP_OFF: after OFF_TICKS strobes → BEEP_ON and increment the beep count.
- PAUSE: after PAUSE_TICKS strobes:
  - burst count == MAX_BURSTS-1 → HOLD with an alarm_timeout pulse;
  - otherwise increment the burst count, clear the beep count, → BEEP_ON.
- Any active state (BEEP_ON, BEEP_OFF, PAUSE):
  - ack = 1 → HOLD;
  - endtime = 0 → IDLE (timer reloaded or restarted).
- HOLD: tone silent; endtime = 0 → IDLE. Because the alarm fires only on a rising edge, it cannot retrigger while the display stays at 00:00.
- Priority in any single cycle: endtime low > ack > tick-driven transition.
- Phase tick counter: cleared on every state entry. It advances on tick, and the state transitions on the cycle where tick = 1 and the count equals N-1.
- Counter widths: $clog2 of the relevant parameter, minimum 1 bit. Counters never wrap; they are cleared on state entry.

## Timing
- All outputs registered. Reset values:
  - tone_en = 0, tone_sel = 0, alarm_active = 0, alarm_timeout = 0;
  - state = IDLE, endtime history = 0.
- Start latency: endtime rise sampled at edge k → tone_en and alarm_active high after edge k+1.
- Ack or endtime-low latency: sampled at edge k → tone_en low after edge k+1.
- Phase length is N-1 to N tick periods, because the first strobe's phase within the state is arbitrary.
- Holding endtime high at reset release does not start an alarm; a fresh 0→1 edge is required.
- Asserting reset_n low mid-alarm silences the tone immediately (asynchronous) and returns to IDLE.

## Configuration
- ALARM_TONE_ROTATE_EN defined:
  - on every PAUSE → BEEP_ON transition, tone_sel advances as (tone_sel + 1) mod 5;
  - the first burst uses the latched value.
- Not defined: tone_sel stays at the value latched at alarm start for the whole alarm.

## Structure
- Shared package egg_timer_pkg holds:
  - the state enum for this block;
  - NUM_TONES = 5 and MAX_TONE = 4, also used by the tone generator for its select decode.
- One sub-module, rise_detect: a registered 0→1 edge detector on endtime. Its history register resets to 0.
- Everything else (FSM, three counters, tone latch) lives in alarm_sequencer.

## Test plan
Bench parameters: ON_TICKS=2, OFF_TICKS=1, BEEPS_PER_BURST=3, PAUSE_TICKS=4, MAX_BURSTS=2, tick every 4 clocks.
- Raise endtime with audioselection=2 and no ack → 3 beeps of 2 ticks with 1-tick gaps, a 4-tick pause, then 3 more beeps. Then a single alarm_timeout pulse, tone_en=0, and state HOLD while endtime stays high.
- Assert ack during the second beep → tone_en low one clock later; endtime falls → IDLE; endtime rises again → a new alarm starts.
- Drop endtime mid-PAUSE → IDLE next clock, no alarm_timeout pulse, alarm_active=0.
- audioselection=7 at the start edge → tone_sel=4. With ALARM_TONE_ROTATE_EN defined, the second burst has tone_sel=0.
- Hold endtime high through reset_n release → no tone. Assert reset_n low during BEEP_ON → all outputs 0 immediately.
- Assert ack and endtime=0 in the same cycle as a tick-driven phase end → state IDLE, not HOLD or BEEP_OFF.
